fir_l3_input_deserializer: RTL and testbench

//   Upstream stage of the 3-parallel reduced-complexity FIR. Accepts one serial sample per

---
 rtl/fir_l3_input_deserializer_pkg.sv | 22 ++
 rtl/fir_l3_input_deserializer_if.sv | 27 ++
 rtl/fir_l3_input_deserializer_block_reg.sv | 34 +++
 rtl/fir_l3_input_deserializer.sv | 90 +++++++++
 tb/tb_fir_l3_input_deserializer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fir_l3_input_deserializer_pkg.sv
// Shared types for the 3-parallel FIR input deserializer: sample and block formats.
// The lane-to-pad mapping lives here so the top and the bench agree on one definition.
package fir_l3_pkg;

    localparam int DATA_IN_WIDTH = 16;
    localparam int LANES         = 3;

    typedef logic signed [DATA_IN_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t    d1;
        sample_t    d2;
        sample_t    d3;
        logic [1:0] pad;
    } block_t;

    // A block closed at lane n carries samples in lanes 0..n; the remainder are zero pad.
    function automatic logic [1:0] pad_for_lane(input logic [1:0] lane);
        return 2'(LANES - 1) - lane;
    endfunction

endpackage

// File: rtl/fir_l3_input_deserializer_if.sv
// Serial-sample input and block-rate output of the FIR input deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface fir_l3_input_deserializer_if
    import fir_l3_pkg::*;
();
    logic    s_valid;
    logic    s_ready;
    sample_t s_data;
    logic    s_last;

    logic       m_valid;
    logic       m_ready;
    sample_t    m_data_1;
    sample_t    m_data_2;
    sample_t    m_data_3;
    logic [1:0] m_pad;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data_1, m_data_2, m_data_3, m_pad
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data_1, m_data_2, m_data_3, m_pad
    );
endinterface

// File: rtl/fir_l3_input_deserializer_block_reg.sv
// Single-entry valid/ready holding register for one sample block.
// Load, drain, and simultaneous load+drain; the caller never loads into a stalled entry.
module fir_l3_block_reg
    import fir_l3_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_load,
    input  block_t i_block,
    input  logic   i_ready,
    output logic   o_valid,
    output block_t o_block
);

    logic   r_valid;
    block_t r_block;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_block <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_block <= i_block;
        end else if (r_valid && i_ready) begin
            // Data is held after the transfer; only the valid flag drops.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_block = r_block;

endmodule

// File: rtl/fir_l3_input_deserializer.sv
// Packs three consecutive serial samples into one block for the L3 FIR block-rate input,
// zero-padding a short final block when the stream ends on s_last.
module fir_l3_input_deserializer
    import fir_l3_pkg::*;
#(
    parameter int DATA_IN_WIDTH = fir_l3_pkg::DATA_IN_WIDTH,
    parameter int LANES         = fir_l3_pkg::LANES
) (
    input  logic                          clk,
    input  logic                          reset,
    fir_l3_input_deserializer_if.slave    bus
);

    generate
        if (LANES != 3 || DATA_IN_WIDTH != fir_l3_pkg::DATA_IN_WIDTH) begin : g_bad_param
            $error("fir_l3_input_deserializer: LANES must be 3 and DATA_IN_WIDTH must match fir_l3_pkg");
        end
    endgenerate

    logic [1:0] r_lane_cnt;
    logic       w_accept;
    logic       w_complete_possible;
    logic       w_complete;
    logic       w_blk_valid;
    block_t     w_block_in;
    block_t     w_block_out;
    sample_t    w_lane [0:LANES-1];

    assign w_complete_possible = (r_lane_cnt == 2'(LANES - 1)) || bus.s_last;
    // Only a block-closing sample can stall, and only when the output entry cannot drain.
    assign bus.s_ready = !(w_complete_possible && w_blk_valid && !bus.m_ready);
    assign w_accept    = bus.s_valid && bus.s_ready;
    assign w_complete  = w_accept && w_complete_possible;

    // Each lane shows its stored sample, the incoming sample, or zero pad.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < LANES - 1) begin : g_stored
                sample_t r_sample;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_sample <= '0;
                    end else if (w_accept && !w_complete && r_lane_cnt == 2'(gi)) begin
                        r_sample <= bus.s_data;
                    end
                end

                assign w_lane[gi] = (r_lane_cnt >  2'(gi)) ? r_sample   :
                                    (r_lane_cnt == 2'(gi)) ? bus.s_data : '0;
            end else begin : g_direct
                // The last lane only ever closes a block, so it is never stored here.
                assign w_lane[gi] = (r_lane_cnt == 2'(gi)) ? bus.s_data : '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_cnt <= '0;
        end else if (w_complete) begin
            r_lane_cnt <= '0;
        end else if (w_accept) begin
            r_lane_cnt <= r_lane_cnt + 2'd1;
        end
    end

    assign w_block_in.d1  = w_lane[0];
    assign w_block_in.d2  = w_lane[1];
    assign w_block_in.d3  = w_lane[2];
    assign w_block_in.pad = pad_for_lane(r_lane_cnt);

    fir_l3_block_reg u_block_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_complete),
        .i_block (w_block_in),
        .i_ready (bus.m_ready),
        .o_valid (w_blk_valid),
        .o_block (w_block_out)
    );

    assign bus.m_valid  = w_blk_valid;
    assign bus.m_data_1 = w_block_out.d1;
    assign bus.m_data_2 = w_block_out.d2;
    assign bus.m_data_3 = w_block_out.d3;
    assign bus.m_pad    = w_block_out.pad;

endmodule

// File: tb/tb_fir_l3_input_deserializer.sv
// Directed bench for the FIR input deserializer: per-cycle vector table plus a reset sequence.
module tb_fir_l3_input_deserializer;
    import fir_l3_pkg::*;

    logic clk;
    logic reset;

    fir_l3_input_deserializer_if bus ();

    fir_l3_input_deserializer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        sample_t    data;
        logic       last;
        logic       m_ready;
        logic       exp_s_ready;
        logic       exp_m_valid;
        sample_t    exp_d1;
        sample_t    exp_d2;
        sample_t    exp_d3;
        logic [1:0] exp_pad;
    } vec_t;

    int n_checks;
    int n_pass;
    int row_id;

    function automatic vec_t mk(input logic v, input int d, input logic l, input logic mr,
                                input logic sr, input logic mv,
                                input int e1, input int e2, input int e3, input int ep);
        vec_t r;
        r.valid       = v;
        r.data        = sample_t'(d);
        r.last        = l;
        r.m_ready     = mr;
        r.exp_s_ready = sr;
        r.exp_m_valid = mv;
        r.exp_d1      = sample_t'(e1);
        r.exp_d2      = sample_t'(e2);
        r.exp_d3      = sample_t'(e3);
        r.exp_pad     = 2'(ep);
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic mv, input sample_t e1, input sample_t e2,
                                 input sample_t e3, input logic [1:0] ep);
        check("m_valid",  idx, 32'(bus.m_valid),  32'(mv));
        check("m_data_1", idx, 32'(bus.m_data_1), 32'(e1));
        check("m_data_2", idx, 32'(bus.m_data_2), 32'(e2));
        check("m_data_3", idx, 32'(bus.m_data_3), 32'(e3));
        check("m_pad",    idx, 32'(bus.m_pad),    32'(ep));
    endtask

    // Inputs are applied 1 time unit after a rising edge; s_ready is checked before the
    // next edge and the registered outputs 1 time unit after it.
    task automatic apply(input vec_t v);
        bus.s_valid = v.valid;
        bus.s_data  = v.data;
        bus.s_last  = v.last;
        bus.m_ready = v.m_ready;
        #1;
        check("s_ready", row_id, 32'(bus.s_ready), 32'(v.exp_s_ready));
        @(posedge clk);
        #1;
        check_outputs(row_id, v.exp_m_valid, v.exp_d1, v.exp_d2, v.exp_d3, v.exp_pad);
        $display("row %0d: v=%0b d=%0d last=%0b mr=%0b -> s_ready=%0b m_valid=%0b {%0d,%0d,%0d} pad=%0d",
                 row_id, v.valid, v.data, v.last, v.m_ready, bus.s_ready, bus.m_valid,
                 bus.m_data_1, bus.m_data_2, bus.m_data_3, bus.m_pad);
        row_id++;
    endtask

    vec_t vecs[$];
    vec_t post_reset[$];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        row_id   = 0;

        // Continuous 1..9, one block every 3 cycles.
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3, 0, 1, 1, 1, 1, 2, 3, 0));
        vecs.push_back(mk(1, 4, 0, 1, 1, 0, 1, 2, 3, 0));
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 1, 2, 3, 0));
        vecs.push_back(mk(1, 6, 0, 1, 1, 1, 4, 5, 6, 0));
        vecs.push_back(mk(1, 7, 0, 1, 1, 0, 4, 5, 6, 0));
        vecs.push_back(mk(1, 8, 0, 1, 1, 0, 4, 5, 6, 0));
        vecs.push_back(mk(1, 9, 0, 1, 1, 1, 7, 8, 9, 0));
        // Backpressure: lanes 0/1 accepted, lane 2 stalls until m_ready rises.
        vecs.push_back(mk(1, 10, 0, 0, 1, 1, 7, 8, 9, 0));
        vecs.push_back(mk(1, 11, 0, 0, 1, 1, 7, 8, 9, 0));
        vecs.push_back(mk(1, 12, 0, 0, 0, 1, 7, 8, 9, 0));
        vecs.push_back(mk(1, 12, 0, 1, 1, 1, 10, 11, 12, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 10, 11, 12, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 10, 11, 12, 0));
        // s_last at lane 0 and lane 1.
        vecs.push_back(mk(1, 30, 1, 1, 1, 1, 30, 0, 0, 2));
        vecs.push_back(mk(1, 20, 0, 1, 1, 0, 30, 0, 0, 2));
        vecs.push_back(mk(1, 21, 1, 1, 1, 1, 20, 21, 0, 1));
        // s_last without s_valid is ignored.
        vecs.push_back(mk(0, 99, 1, 1, 1, 0, 20, 21, 0, 1));
        // s_last stalls under backpressure; a non-last lane-0 sample still goes in.
        vecs.push_back(mk(1, 40, 1, 0, 1, 1, 40, 0, 0, 2));
        vecs.push_back(mk(1, 50, 1, 0, 0, 1, 40, 0, 0, 2));
        vecs.push_back(mk(1, 50, 0, 0, 1, 1, 40, 0, 0, 2));
        vecs.push_back(mk(1, 51, 1, 1, 1, 1, 50, 51, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 50, 51, 0, 1));
        // Extremes pass bit-exact.
        vecs.push_back(mk(1, -32768, 0, 1, 1, 0, 50, 51, 0, 1));
        vecs.push_back(mk(1, -1,     0, 1, 1, 0, 50, 51, 0, 1));
        vecs.push_back(mk(1, 32767,  0, 1, 1, 1, 'h8000, 'hFFFF, 'h7FFF, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h8000, 'hFFFF, 'h7FFF, 0));
        // Fill the output entry, then leave two samples pending before a reset.
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 'h8000, 'hFFFF, 'h7FFF, 0));
        vecs.push_back(mk(1, 2, 0, 0, 1, 0, 'h8000, 'hFFFF, 'h7FFF, 0));
        vecs.push_back(mk(1, 3, 0, 0, 1, 1, 1, 2, 3, 0));
        vecs.push_back(mk(1, 4, 0, 0, 1, 1, 1, 2, 3, 0));
        vecs.push_back(mk(1, 5, 0, 0, 1, 1, 1, 2, 3, 0));

        // After reset the partial {4,5} must be gone.
        post_reset.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0, 0));
        post_reset.push_back(mk(1, 8, 0, 1, 1, 0, 0, 0, 0, 0));
        post_reset.push_back(mk(1, 9, 0, 1, 1, 1, 7, 8, 9, 0));

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset s_ready", -1, 32'(bus.s_ready), 32'd1);
        check_outputs(-1, 1'b0, '0, '0, '0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midblock reset s_ready", -2, 32'(bus.s_ready), 32'd1);
        check_outputs(-2, 1'b0, '0, '0, '0, 2'd0);
        $display("midblock reset: m_valid=%0b {%0d,%0d,%0d} pad=%0d",
                 bus.m_valid, bus.m_data_1, bus.m_data_2, bus.m_data_3, bus.m_pad);
        @(posedge clk);
        #1;

        for (int i = 0; i < post_reset.size(); i++) begin
            apply(post_reset[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
